// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multi-cycle RV32I control unit: FSM states,
// opcode constants, ALU / write-back / branch-type encodings, instruction
// classes and the funct3 -> alu_op helper used by the decoder.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_MULDIV = 3'd5,
    ST_TRAP   = 3'd6
  } state_e;

  typedef enum logic [3:0] {
    CLS_R,
    CLS_I,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_LUI,
    CLS_AUIPC,
    CLS_JAL,
    CLS_JALR,
    CLS_MULDIV
  } cls_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_SLTI  = 4'd10;
  localparam logic [3:0] ALU_SLTIU = 4'd11;
  localparam logic [3:0] ALU_LUI   = 4'd12;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [2:0] BR_NEVER  = 3'd2;
  localparam logic [2:0] BR_ALWAYS = 3'd3;

  // alt is ir[30]: selects SUB (register form only) and SRA/SRAI.
  function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3,
                                                 input logic       alt,
                                                 input logic       imm);
    logic [3:0] op;
    case (f3)
      3'b000:  op = (alt && !imm) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = imm ? ALU_SLTI : ALU_SLT;
      3'b011:  op = imm ? ALU_SLTIU : ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Instruction / data memory handshake bundle between the control unit
// (master) and the memory subsystem (slave).
interface multicycle_controller_if;
  logic        imem_req;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic        dmem_req;
  logic        dmem_ack;

  modport master (output imem_req, dmem_req,
                  input  imem_rdata, imem_ack, dmem_ack);
  modport slave  (input  imem_req, dmem_req,
                  output imem_rdata, imem_ack, dmem_ack);
endinterface

// File: rtl/multicycle_controller_inst_decoder.sv
// Combinational instruction classifier: maps the instruction register to
// an instruction class, an ALU operation and a legality flag.
// Optional feature macro RV32M_EN: accepts R-type funct7=0x01 (MUL/DIV).
module inst_decoder
  import ctrl_pkg::*;
(
  input  logic [31:0] ir_i,
  output cls_e        cls_o,
  output logic [3:0]  alu_op_o,
  output logic        legal_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_ir_bits;

  assign opcode = ir_i[6:0];
  assign funct3 = ir_i[14:12];
  assign funct7 = ir_i[31:25];
  // Register specifiers and immediates are the datapath's business.
  assign unused_ir_bits = ^{ir_i[24:15], ir_i[11:7]};

  // Opcode / funct decode into class, ALU op and legality.
  always_comb begin
    cls_o    = CLS_I;
    alu_op_o = ALU_ADD;
    legal_o  = 1'b0;
    case (opcode)
      OP_R: begin
        cls_o    = CLS_R;
        alu_op_o = alu_from_funct3(funct3, ir_i[30], 1'b0);
        legal_o  = (funct7 == 7'h00) || (funct7 == 7'h20);
`ifdef RV32M_EN
        if (funct7 == 7'h01) begin
          cls_o    = CLS_MULDIV;
          alu_op_o = ALU_ADD;
          legal_o  = 1'b1;
        end
`endif
      end
      OP_I: begin
        cls_o    = CLS_I;
        alu_op_o = alu_from_funct3(funct3, ir_i[30], 1'b1);
        legal_o  = 1'b1;
      end
      OP_LOAD:   begin cls_o = CLS_LOAD;   legal_o = 1'b1; end
      OP_STORE:  begin cls_o = CLS_STORE;  legal_o = 1'b1; end
      OP_BRANCH: begin cls_o = CLS_BRANCH; legal_o = 1'b1; end
      OP_LUI: begin
        cls_o    = CLS_LUI;
        alu_op_o = ALU_LUI;
        legal_o  = 1'b1;
      end
      OP_AUIPC:  begin cls_o = CLS_AUIPC;  legal_o = 1'b1; end
      OP_JAL:    begin cls_o = CLS_JAL;    legal_o = 1'b1; end
      OP_JALR:   begin cls_o = CLS_JALR;   legal_o = 1'b1; end
      default:   legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control unit: owns the instruction register and the
// FETCH/DECODE/EXEC/MEM/WB sequencer, handles variable-latency memories
// with a timeout, and traps on illegal instructions.
// Optional feature macro RV32M_EN: enables the MULDIV state and md_start.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT   = 255,
  parameter int MULDIV_CYCLES = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  multicycle_controller_if.master mem_if,
  input  logic                    br_taken_i,
  output logic [31:0]             ir_o,
  output logic                    ir_wr_o,
  output logic                    pc_wr_o,
  output logic                    reg_wr_o,
  output logic                    mem_rd_o,
  output logic                    mem_wr_o,
  output logic                    pc_sel_o,
  output logic                    sel_a_o,
  output logic                    sel_b_o,
  output logic [3:0]              alu_op_o,
  output logic [2:0]              br_type_o,
  output logic [1:0]              wb_sel_o,
  output logic                    md_start_o,
  output logic                    trap_o,
  output logic [2:0]              state_o
);

  localparam int            TW       = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(MEM_TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [31:0]   ir_q;
  logic [TW-1:0] tmo_q, tmo_d;
  cls_e          dec_cls;
  logic [3:0]    dec_alu_op;
  logic          dec_legal;
  logic          imem_req_c, dmem_req_c;
  logic          mem_wait, tmo_hit;

  inst_decoder u_dec (
    .ir_i     (ir_q),
    .cls_o    (dec_cls),
    .alu_op_o (dec_alu_op),
    .legal_o  (dec_legal)
  );

  // A memory wait cycle is a req cycle without ack; the cycle that would
  // bring the counter to MEM_TIMEOUT traps, unless ack shows up in it.
  assign mem_wait = ((state_q == ST_FETCH) && !mem_if.imem_ack) ||
                    ((state_q == ST_MEM)   && !mem_if.dmem_ack);
  assign tmo_hit  = mem_wait && (tmo_q == TMO_LAST);

`ifdef RV32M_EN
  localparam int            MW      = $clog2(MULDIV_CYCLES + 1);
  localparam logic [MW-1:0] MD_LAST = MW'(MULDIV_CYCLES - 1);
  logic [MW-1:0] md_cnt_q;

  // MUL/DIV latency counter, restarted on every entry to MULDIV.
  always_ff @(posedge clk) begin
    if (rst || (state_q != ST_MULDIV)) md_cnt_q <= '0;
    else                               md_cnt_q <= md_cnt_q + 1'b1;
  end
`else
  logic [31:0] unused_md_cycles;
  assign unused_md_cycles = 32'(MULDIV_CYCLES);
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_FETCH;
    else     state_q <= state_d;
  end

  // Instruction register, loaded on the FETCH ack cycle only.
  always_ff @(posedge clk) begin
    if (rst)          ir_q <= '0;
    else if (ir_wr_o) ir_q <= mem_if.imem_rdata;
  end

  // Memory timeout counter register.
  always_ff @(posedge clk) begin
    if (rst) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end

  // Timeout counter: cleared on any state change, counts missing acks.
  always_comb begin
    tmo_d = tmo_q;
    if (state_d != state_q) tmo_d = '0;
    else if (mem_wait)      tmo_d = tmo_q + 1'b1;
  end

  // Next-state and control outputs; everything idles while rst is high so
  // a stale ack during reset cannot load the IR.
  always_comb begin
    state_d    = state_q;
    imem_req_c = 1'b0;
    dmem_req_c = 1'b0;
    ir_wr_o    = 1'b0;
    pc_wr_o    = 1'b0;
    reg_wr_o   = 1'b0;
    mem_rd_o   = 1'b0;
    mem_wr_o   = 1'b0;
    pc_sel_o   = 1'b0;
    sel_a_o    = 1'b1;
    sel_b_o    = 1'b0;
    alu_op_o   = ALU_ADD;
    br_type_o  = BR_NEVER;
    wb_sel_o   = WB_ALU;
    md_start_o = 1'b0;
    if (!rst) begin
      // Operand selection is held from EXEC through WB so the ALU result
      // (address, jump target, write-back value) stays valid.
      if (state_q inside {ST_EXEC, ST_MEM, ST_WB, ST_MULDIV}) begin
        alu_op_o = dec_alu_op;
        sel_b_o  = 1'b1;
        case (dec_cls)
          CLS_R, CLS_MULDIV:             sel_b_o = 1'b0;
          CLS_BRANCH, CLS_AUIPC, CLS_JAL: sel_a_o = 1'b0;
          default: ;
        endcase
      end
      case (state_q)
        ST_FETCH: begin
          imem_req_c = 1'b1;
          if (mem_if.imem_ack) begin
            ir_wr_o = 1'b1;
            state_d = ST_DECODE;
          end else if (tmo_hit) begin
            state_d = ST_TRAP;
          end
        end
        ST_DECODE: state_d = dec_legal ? ST_EXEC : ST_TRAP;
        ST_EXEC: begin
          case (dec_cls)
            CLS_LOAD, CLS_STORE: state_d = ST_MEM;
            CLS_BRANCH: begin
              br_type_o = ir_q[14:12];
              pc_wr_o   = 1'b1;
              pc_sel_o  = br_taken_i;
              state_d   = ST_FETCH;
            end
            CLS_MULDIV: begin
`ifdef RV32M_EN
              md_start_o = 1'b1;
              state_d    = ST_MULDIV;
`else
              state_d    = ST_TRAP;
`endif
            end
            default: state_d = ST_WB;
          endcase
        end
        ST_MEM: begin
          dmem_req_c = 1'b1;
          mem_rd_o   = (dec_cls == CLS_LOAD);
          mem_wr_o   = (dec_cls == CLS_STORE);
          if (mem_if.dmem_ack) begin
            if (dec_cls == CLS_STORE) begin
              pc_wr_o = 1'b1;
              state_d = ST_FETCH;
            end else begin
              state_d = ST_WB;
            end
          end else if (tmo_hit) begin
            state_d = ST_TRAP;
          end
        end
        ST_WB: begin
          reg_wr_o = 1'b1;
          pc_wr_o  = 1'b1;
          pc_sel_o = (dec_cls == CLS_JAL) || (dec_cls == CLS_JALR);
          if (dec_cls == CLS_LOAD)                               wb_sel_o = WB_MEM;
          else if ((dec_cls == CLS_JAL) || (dec_cls == CLS_JALR)) wb_sel_o = WB_PC4;
          state_d  = ST_FETCH;
        end
        ST_MULDIV: begin
`ifdef RV32M_EN
          if (md_cnt_q == MD_LAST) state_d = ST_WB;
`else
          state_d = ST_TRAP;
`endif
        end
        ST_TRAP: state_d = ST_TRAP;
        default: state_d = ST_TRAP;
      endcase
    end
  end

  assign mem_if.imem_req = imem_req_c;
  assign mem_if.dmem_req = dmem_req_c;
  assign ir_o            = ir_q;
  assign trap_o          = !rst && (state_q == ST_TRAP);
  assign state_o         = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller (MEM_TIMEOUT=4): runs single
// instructions with chosen memory latencies and checks cycle counts,
// state sequences and strobe values against hand-computed expectations.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        br_taken;
  logic [31:0] ir;
  logic        ir_wr, pc_wr, reg_wr, mem_rd, mem_wr, pc_sel, sel_a, sel_b;
  logic        md_start, trap;
  logic [3:0]  alu_op;
  logic [2:0]  br_type, state;
  logic [1:0]  wb_sel;

  int n_checks = 0;
  int n_pass   = 0;

  // Per-instruction record filled by run_instr.
  int          cycles, n_reg_wr, n_pc_wr, n_mem_rd, n_mem_wr, n_md_start, n_muldiv;
  logic [31:0] seq;
  logic [3:0]  wb_alu;
  logic [1:0]  wb_wbsel;
  logic        wb_pcsel, ex_pcwr, ex_pcsel, ex_sela, ex_selb;
  logic [2:0]  ex_brtype;

  always #5 clk = ~clk;

  multicycle_controller_if mem();

  multicycle_controller #(.MEM_TIMEOUT(4), .MULDIV_CYCLES(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_if     (mem),
    .br_taken_i (br_taken),
    .ir_o       (ir),
    .ir_wr_o    (ir_wr),
    .pc_wr_o    (pc_wr),
    .reg_wr_o   (reg_wr),
    .mem_rd_o   (mem_rd),
    .mem_wr_o   (mem_wr),
    .pc_sel_o   (pc_sel),
    .sel_a_o    (sel_a),
    .sel_b_o    (sel_b),
    .alu_op_o   (alu_op),
    .br_type_o  (br_type),
    .wb_sel_o   (wb_sel),
    .md_start_o (md_start),
    .trap_o     (trap),
    .state_o    (state)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every control output at its reset value (called while rst is high).
  task automatic check_reset_outputs(input string tag);
    check_eq({tag, ".state"},   32'(state), 0);
    check_eq({tag, ".req"},     32'({mem.imem_req, mem.dmem_req}), 0);
    check_eq({tag, ".strobes"}, 32'({ir_wr, pc_wr, reg_wr, mem_rd, mem_wr, md_start}), 0);
    check_eq({tag, ".ir"},      ir, 0);
    check_eq({tag, ".trap"},    32'(trap), 0);
    check_eq({tag, ".sel_a"},   32'(sel_a), 1);
    check_eq({tag, ".sel_b"},   32'(sel_b), 0);
    check_eq({tag, ".alu_op"},  32'(alu_op), 0);
    check_eq({tag, ".wb_sel"},  32'(wb_sel), 0);
    check_eq({tag, ".br_type"}, 32'(br_type), 2);
    check_eq({tag, ".pc_sel"},  32'(pc_sel), 0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    mem.imem_ack = 1'b0;
    mem.dmem_ack = 1'b0;
    tick();
    check_reset_outputs(tag);
    rst = 1'b0;
  endtask

  // Runs one instruction from FETCH until it returns to FETCH or traps.
  // imem/dmem ack arrive after iwait/dwait wait cycles.
  task automatic run_instr(input string name, input logic [31:0] instr,
                           input int iwait, input int dwait, input logic br);
    int   fc, dc;
    bit   left, done;
    logic [2:0] st;
    fc = 0; dc = 0; left = 0; done = 0;
    cycles = 0; seq = 0;
    n_reg_wr = 0; n_pc_wr = 0; n_mem_rd = 0; n_mem_wr = 0; n_md_start = 0; n_muldiv = 0;
    wb_alu = 'x; wb_wbsel = 'x; wb_pcsel = 'x;
    ex_pcwr = 'x; ex_pcsel = 'x; ex_brtype = 'x; ex_sela = 'x; ex_selb = 'x;
    while (!done && cycles < 100) begin
      st = state;
      mem.imem_rdata = instr;
      mem.imem_ack   = (st == 3'd0) && (fc == iwait);
      mem.dmem_ack   = (st == 3'd3) && (dc == dwait);
      br_taken       = br;
      #1;
      seq = {seq[28:0], st};
      n_reg_wr   += int'(reg_wr);
      n_pc_wr    += int'(pc_wr);
      n_mem_rd   += int'(mem_rd);
      n_mem_wr   += int'(mem_wr);
      n_md_start += int'(md_start);
      if (st == 3'd5) n_muldiv++;
      if (st == 3'd2) begin
        ex_pcwr = pc_wr; ex_pcsel = pc_sel; ex_brtype = br_type;
        ex_sela = sel_a; ex_selb = sel_b;
      end
      if (st == 3'd4) begin
        wb_alu = alu_op; wb_wbsel = wb_sel; wb_pcsel = pc_sel;
      end
      if (st == 3'd0) fc++;
      if (st == 3'd3) dc++;
      if (st != 3'd0) left = 1;
      cycles++;
      tick();
      if ((left && state == 3'd0) || state == 3'd6) done = 1;
    end
    mem.imem_ack = 1'b0;
    mem.dmem_ack = 1'b0;
    if (!done) check_eq({name, ".cycle_budget"}, 32'(cycles), 0);
    $display("txn %s: instr=%08h cycles=%0d end_state=%0d", name, instr, cycles, state);
  endtask

  // Trap must hold with no requests even if the memories keep acking.
  task automatic check_trap_hold(input string tag);
    mem.imem_ack = 1'b1;
    mem.dmem_ack = 1'b1;
    repeat (3) tick();
    check_eq({tag, ".state"}, 32'(state), 6);
    check_eq({tag, ".trap"},  32'(trap), 1);
    check_eq({tag, ".req"},   32'({mem.imem_req, mem.dmem_req}), 0);
    check_eq({tag, ".strb"},  32'({ir_wr, pc_wr, reg_wr, mem_rd, mem_wr}), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset with a stale ack present: it must not load the IR.
    rst = 1'b1;
    br_taken = 1'b0;
    mem.imem_ack   = 1'b1;
    mem.imem_rdata = 32'hDEADBEEF;
    mem.dmem_ack   = 1'b1;
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    mem.imem_ack = 1'b0;
    mem.dmem_ack = 1'b0;
    #1;
    check_eq("post_reset.ir",  ir, 0);
    check_eq("post_reset.req", 32'(mem.imem_req), 1);

    run_instr("add", 32'h002081B3, 0, 0, 1'b0);
    check_eq("add.cycles", 32'(cycles), 4);
    check_eq("add.seq",    seq, 32'o124);
    check_eq("add.reg_wr", 32'(n_reg_wr), 1);
    check_eq("add.pc_wr",  32'(n_pc_wr), 1);
    check_eq("add.alu_op", 32'(wb_alu), 0);
    check_eq("add.wb_sel", 32'(wb_wbsel), 0);
    check_eq("add.ir",     ir, 32'h002081B3);

    run_instr("lw_wait3", 32'h0000A183, 0, 3, 1'b0);
    check_eq("lw.cycles", 32'(cycles), 8);
    check_eq("lw.seq",    seq, 32'o1233334);
    check_eq("lw.mem_rd", 32'(n_mem_rd), 4);
    check_eq("lw.wb_sel", 32'(wb_wbsel), 1);
    check_eq("lw.reg_wr", 32'(n_reg_wr), 1);

    run_instr("beq_taken", 32'h00208463, 0, 0, 1'b1);
    check_eq("beq.cycles",  32'(cycles), 3);
    check_eq("beq.seq",     seq, 32'o12);
    check_eq("beq.pc_wr",   32'(ex_pcwr), 1);
    check_eq("beq.pc_sel",  32'(ex_pcsel), 1);
    check_eq("beq.br_type", 32'(ex_brtype), 0);
    check_eq("beq.sel_ab",  32'({ex_sela, ex_selb}), 1);
    check_eq("beq.reg_wr",  32'(n_reg_wr), 0);

    run_instr("bne_not", 32'h00209463, 0, 0, 1'b0);
    check_eq("bne.pc_sel",  32'(ex_pcsel), 0);
    check_eq("bne.br_type", 32'(ex_brtype), 1);

    run_instr("sw", 32'h0020A023, 0, 0, 1'b0);
    check_eq("sw.cycles", 32'(cycles), 4);
    check_eq("sw.mem_wr", 32'(n_mem_wr), 1);
    check_eq("sw.pc_wr",  32'(n_pc_wr), 1);
    check_eq("sw.reg_wr", 32'(n_reg_wr), 0);

    run_instr("sub", 32'h402081B3, 0, 0, 1'b0);
    check_eq("sub.alu_op", 32'(wb_alu), 1);
    run_instr("srai", 32'h4020D193, 0, 0, 1'b0);
    check_eq("srai.alu_op", 32'(wb_alu), 7);
    run_instr("addi_neg", 32'hC0008193, 0, 0, 1'b0);
    check_eq("addi_neg.alu_op", 32'(wb_alu), 0);
    run_instr("slti", 32'h0020A193, 0, 0, 1'b0);
    check_eq("slti.alu_op", 32'(wb_alu), 10);
    run_instr("lui", 32'h123451B7, 0, 0, 1'b0);
    check_eq("lui.alu_op", 32'(wb_alu), 12);
    check_eq("lui.cycles", 32'(cycles), 4);

    run_instr("jal", 32'h008000EF, 0, 0, 1'b0);
    check_eq("jal.cycles", 32'(cycles), 4);
    check_eq("jal.wb_sel", 32'(wb_wbsel), 2);
    check_eq("jal.pc_sel", 32'(wb_pcsel), 1);
    check_eq("jal.reg_wr", 32'(n_reg_wr), 1);

    // Ack on the last allowed fetch cycle wins over the timeout.
    run_instr("add_iwait3", 32'h002081B3, 3, 0, 1'b0);
    check_eq("iwait3.cycles", 32'(cycles), 7);
    check_eq("iwait3.state",  32'(state), 0);

`ifdef RV32M_EN
    run_instr("mul", 32'h022081B3, 0, 0, 1'b0);
    check_eq("mul.cycles",   32'(cycles), 36);
    check_eq("mul.md_start", 32'(n_md_start), 1);
    check_eq("mul.muldiv",   32'(n_muldiv), 32);
    check_eq("mul.reg_wr",   32'(n_reg_wr), 1);
    check_eq("mul.wb_sel",   32'(wb_wbsel), 0);
`else
    run_instr("mul", 32'h022081B3, 0, 0, 1'b0);
    check_eq("mul.cycles",   32'(cycles), 2);
    check_eq("mul.state",    32'(state), 6);
    check_eq("mul.md_start", 32'(n_md_start), 0);
    do_reset("rst_after_mul");
`endif

    run_instr("lw_dmem_timeout", 32'h0000A183, 0, 1000, 1'b0);
    check_eq("dtmo.cycles", 32'(cycles), 7);
    check_eq("dtmo.state",  32'(state), 6);
    check_eq("dtmo.mem_rd", 32'(n_mem_rd), 4);
    check_trap_hold("dtmo.hold");
    do_reset("rst_after_dtmo");

    run_instr("imem_timeout", 32'h002081B3, 1000, 0, 1'b0);
    check_eq("itmo.cycles", 32'(cycles), 4);
    check_eq("itmo.state",  32'(state), 6);
    check_trap_hold("itmo.hold");
    do_reset("rst_after_itmo");

    run_instr("opcode_7f", 32'h0000007F, 0, 0, 1'b0);
    check_eq("op7f.cycles", 32'(cycles), 2);
    check_eq("op7f.state",  32'(state), 6);
    check_eq("op7f.trap",   32'(trap), 1);
    do_reset("rst_in_trap");

    run_instr("r_funct7_bad", 32'h202081B3, 0, 0, 1'b0);
    check_eq("f7bad.cycles", 32'(cycles), 2);
    check_eq("f7bad.state",  32'(state), 6);
    do_reset("rst_after_f7bad");

    run_instr("add_after_reset", 32'h002081B3, 0, 0, 1'b0);
    check_eq("add2.cycles", 32'(cycles), 4);
    check_eq("add2.seq",    seq, 32'o124);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
